// File: rtl/e203_exu_flush_ctrl_if.sv
// Flush handshake bundle between the commit sources (exception/branch), the flush controller and the IFU.
// The pipe_flush_pc signal exists only when E203_FLUSH_PC_PRECALC_EN is defined.
interface e203_exu_flush_ctrl_if #(
    parameter int PC_SIZE = 32
);
    logic               excp_flush_req;
    logic [PC_SIZE-1:0] excp_flush_add_op1;
    logic [PC_SIZE-1:0] excp_flush_add_op2;
    logic               excp_flush_ack;

    logic               brch_flush_req;
    logic [PC_SIZE-1:0] brch_flush_add_op1;
    logic [PC_SIZE-1:0] brch_flush_add_op2;
    logic               brch_flush_ack;

    // valid/ready: a source holds *_req and its operands until the matching *_ack is seen high
    // at a rising edge; the controller holds pipe_flush_req and operands until pipe_flush_ack.
    logic               pipe_flush_req;
    logic               pipe_flush_ack;
    logic [PC_SIZE-1:0] pipe_flush_add_op1;
    logic [PC_SIZE-1:0] pipe_flush_add_op2;
    logic               pipe_flush_src;
    logic               flush_busy;
`ifdef E203_FLUSH_PC_PRECALC_EN
    logic [PC_SIZE-1:0] pipe_flush_pc;
`endif

    modport slave (
        input  excp_flush_req, excp_flush_add_op1, excp_flush_add_op2,
        output excp_flush_ack,
        input  brch_flush_req, brch_flush_add_op1, brch_flush_add_op2,
        output brch_flush_ack,
        input  pipe_flush_ack,
        output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
        output pipe_flush_src, flush_busy
`ifdef E203_FLUSH_PC_PRECALC_EN
        , output pipe_flush_pc
`endif
    );

    modport master (
        output excp_flush_req, excp_flush_add_op1, excp_flush_add_op2,
        input  excp_flush_ack,
        output brch_flush_req, brch_flush_add_op1, brch_flush_add_op2,
        input  brch_flush_ack,
        output pipe_flush_ack,
        input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
        input  pipe_flush_src, flush_busy
`ifdef E203_FLUSH_PC_PRECALC_EN
        , input pipe_flush_pc
`endif
    );
endinterface

// File: rtl/e203_exu_flush_ctrl.sv
// Arbitrates exception/branch flush requests into one registered IFU flush, followed by a FLUSH_GAP idle window.
// Optional E203_FLUSH_PC_PRECALC_EN adds a registered op1+op2 target on pipe_flush_pc.
module e203_exu_flush_ctrl #(
    parameter int PC_SIZE   = 32,
    parameter int FLUSH_GAP = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    e203_exu_flush_ctrl_if.slave  flush_if,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = (FLUSH_GAP > 0) ? 4'(FLUSH_GAP - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [PC_SIZE-1:0] op1_q, op2_q;
    logic               src_q;
    logic               excp_ack, brch_ack, cap_en;
    logic [PC_SIZE-1:0] cap_op1, cap_op2;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        excp_ack  = 1'b0;
        brch_ack  = 1'b0;
        cap_en    = 1'b0;
        cap_op1   = flush_if.excp_flush_req ? flush_if.excp_flush_add_op1 : flush_if.brch_flush_add_op1;
        cap_op2   = flush_if.excp_flush_req ? flush_if.excp_flush_add_op2 : flush_if.brch_flush_add_op2;
        case (state_q)
            ST_IDLE: begin
                // Exceptions always win; a simultaneous branch request stays pending.
                if (flush_if.excp_flush_req) begin
                    excp_ack = 1'b1;
                    cap_en   = 1'b1;
                    state_d  = ST_PEND;
                end else if (flush_if.brch_flush_req) begin
                    brch_ack = 1'b1;
                    cap_en   = 1'b1;
                    state_d  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (flush_if.pipe_flush_ack) begin
                    if (FLUSH_GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Nothing is accepted while reset is asserted.
        if (!rst_n) begin
            excp_ack = 1'b0;
            brch_ack = 1'b0;
            cap_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= 4'd0;
            op1_q     <= '0;
            op2_q     <= '0;
            src_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            if (cap_en) begin
                op1_q <= cap_op1;
                op2_q <= cap_op2;
                src_q <= excp_ack;
            end
        end
    end

`ifdef E203_FLUSH_PC_PRECALC_EN
    logic [PC_SIZE-1:0] pc_q;

    // Carry out of the add is dropped: the target wraps modulo 2^PC_SIZE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (cap_en) begin
            pc_q <= cap_op1 + cap_op2;
        end
    end

    assign flush_if.pipe_flush_pc = pc_q;
`endif

    assign flush_if.excp_flush_ack     = excp_ack;
    assign flush_if.brch_flush_ack     = brch_ack;
    assign flush_if.pipe_flush_req     = (state_q == ST_PEND);
    assign flush_if.pipe_flush_add_op1 = op1_q;
    assign flush_if.pipe_flush_add_op2 = op2_q;
    assign flush_if.pipe_flush_src     = src_q;
    assign flush_if.flush_busy         = (state_q != ST_IDLE);
    assign dbg_state_o                 = state_q;

endmodule

// File: tb/tb_e203_exu_flush_ctrl.sv
// Bench for e203_exu_flush_ctrl: directed scenarios on a FLUSH_GAP=2 and a FLUSH_GAP=0 instance,
// plus a randomized run against a transaction-level model.
module tb_e203_exu_flush_ctrl;
    localparam int PC_SIZE = 32;
    localparam int GAP0    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg0, dbg1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    e203_exu_flush_ctrl_if #(.PC_SIZE(PC_SIZE)) if0 ();
    e203_exu_flush_ctrl_if #(.PC_SIZE(PC_SIZE)) if1 ();

    e203_exu_flush_ctrl #(.PC_SIZE(PC_SIZE), .FLUSH_GAP(GAP0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_if(if0.slave), .dbg_state_o(dbg0));
    e203_exu_flush_ctrl #(.PC_SIZE(PC_SIZE), .FLUSH_GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_if(if1.slave), .dbg_state_o(dbg1));

    // ---------------- clock/reset and driver tasks ----------------
    task automatic idle_inputs();
        if0.excp_flush_req = 1'b0; if0.excp_flush_add_op1 = '0; if0.excp_flush_add_op2 = '0;
        if0.brch_flush_req = 1'b0; if0.brch_flush_add_op1 = '0; if0.brch_flush_add_op2 = '0;
        if0.pipe_flush_ack = 1'b0;
        if1.excp_flush_req = 1'b0; if1.excp_flush_add_op1 = '0; if1.excp_flush_add_op2 = '0;
        if1.brch_flush_req = 1'b0; if1.brch_flush_add_op1 = '0; if1.brch_flush_add_op2 = '0;
        if1.pipe_flush_ack = 1'b0;
    endtask

    // Completes a pending flush on if0 and waits out the gap.
    task automatic complete_flush0();
        @(negedge clk);
        if0.pipe_flush_ack = 1'b1;
        @(negedge clk);
        if0.pipe_flush_ack = 1'b0;
        repeat (GAP0) @(negedge clk);
    endtask

    task automatic drive_brch0(input logic [31:0] a, input logic [31:0] b);
        if0.brch_flush_req = 1'b1; if0.brch_flush_add_op1 = a; if0.brch_flush_add_op2 = b;
    endtask

    task automatic drive_excp0(input logic [31:0] a, input logic [31:0] b);
        if0.excp_flush_req = 1'b1; if0.excp_flush_add_op1 = a; if0.excp_flush_add_op2 = b;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_excp0(32'h1111_0000, 32'h2);
        drive_brch0(32'h2222_0000, 32'h4);
        @(negedge clk); @(negedge clk); #1;
        checks++; if (if0.excp_flush_ack !== 1'b0) begin errors++; $display("FAIL reset_excp_ack: got %b exp 0", if0.excp_flush_ack); end
        checks++; if (if0.brch_flush_ack !== 1'b0) begin errors++; $display("FAIL reset_brch_ack: got %b exp 0", if0.brch_flush_ack); end
        checks++; if (if0.pipe_flush_req !== 1'b0) begin errors++; $display("FAIL reset_pipe_req: got %b exp 0", if0.pipe_flush_req); end
        checks++; if (if0.flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", if0.flush_busy); end
        checks++; if (if0.pipe_flush_add_op1 !== 32'h0) begin errors++; $display("FAIL reset_op1: got %h exp 0", if0.pipe_flush_add_op1); end
        checks++; if (if0.pipe_flush_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %b exp 0", if0.pipe_flush_src); end
        checks++; if (dbg0 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg0); end
`ifdef E203_FLUSH_PC_PRECALC_EN
        checks++; if (if0.pipe_flush_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", if0.pipe_flush_pc); end
`endif
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_brch_basic();
        @(negedge clk);
        drive_brch0(32'h8000_0100, 32'h0000_0004);
        #1;
        checks++; if (if0.brch_flush_ack !== 1'b1) begin errors++; $display("FAIL basic_brch_ack: got %b exp 1", if0.brch_flush_ack); end
        checks++; if (if0.pipe_flush_req !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b exp 0", if0.pipe_flush_req); end
        @(negedge clk);
        idle_inputs();
        if0.pipe_flush_ack = 1'b1;
        #1;
        checks++; if (if0.pipe_flush_req !== 1'b1) begin errors++; $display("FAIL basic_pipe_req: got %b exp 1", if0.pipe_flush_req); end
        checks++; if (if0.pipe_flush_add_op1 !== 32'h8000_0100) begin errors++; $display("FAIL basic_op1: got %h exp 80000100", if0.pipe_flush_add_op1); end
        checks++; if (if0.pipe_flush_add_op2 !== 32'h0000_0004) begin errors++; $display("FAIL basic_op2: got %h exp 4", if0.pipe_flush_add_op2); end
        checks++; if (if0.pipe_flush_src !== 1'b0) begin errors++; $display("FAIL basic_src: got %b exp 0", if0.pipe_flush_src); end
`ifdef E203_FLUSH_PC_PRECALC_EN
        checks++; if (if0.pipe_flush_pc !== 32'h8000_0104) begin errors++; $display("FAIL basic_pc: got %h exp 80000104", if0.pipe_flush_pc); end
`endif
        // Gap must keep the block busy for exactly GAP0 cycles.
        for (int i = 0; i < GAP0 + 1; i++) begin
            @(negedge clk);
            if0.pipe_flush_ack = 1'b0;
            #1;
            checks++; if (if0.flush_busy !== (i < GAP0)) begin errors++; $display("FAIL basic_gap_busy[%0d]: got %b exp %b", i, if0.flush_busy, (i < GAP0)); end
            checks++; if (if0.pipe_flush_req !== 1'b0) begin errors++; $display("FAIL basic_gap_req[%0d]: got %b exp 0", i, if0.pipe_flush_req); end
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        drive_excp0(32'hA000_0000, 32'h10);
        drive_brch0(32'hB000_0000, 32'h20);
        #1;
        checks++; if (if0.excp_flush_ack !== 1'b1) begin errors++; $display("FAIL prio_excp_ack: got %b exp 1", if0.excp_flush_ack); end
        checks++; if (if0.brch_flush_ack !== 1'b0) begin errors++; $display("FAIL prio_brch_ack: got %b exp 0", if0.brch_flush_ack); end
        @(negedge clk);
        if0.excp_flush_req = 1'b0;
        #1;
        checks++; if (if0.pipe_flush_src !== 1'b1) begin errors++; $display("FAIL prio_src: got %b exp 1", if0.pipe_flush_src); end
        checks++; if (if0.pipe_flush_add_op1 !== 32'hA000_0000) begin errors++; $display("FAIL prio_op1: got %h exp a0000000", if0.pipe_flush_add_op1); end
        // PEND with ack, then GAP0 gap cycles: branch must not be acked in any of them.
        for (int i = 0; i < GAP0 + 1; i++) begin
            @(negedge clk);
            if0.pipe_flush_ack = (i == 0);
            #1;
            checks++; if (if0.brch_flush_ack !== 1'b0) begin errors++; $display("FAIL prio_brch_wait[%0d]: got %b exp 0", i, if0.brch_flush_ack); end
        end
        @(negedge clk);
        if0.pipe_flush_ack = 1'b0;
        #1;
        checks++; if (if0.brch_flush_ack !== 1'b1) begin errors++; $display("FAIL prio_brch_late_ack: got %b exp 1", if0.brch_flush_ack); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (if0.pipe_flush_src !== 1'b0 || if0.pipe_flush_add_op1 !== 32'hB000_0000) begin errors++; $display("FAIL prio_brch_capture: got src=%b op1=%h exp src=0 op1=b0000000", if0.pipe_flush_src, if0.pipe_flush_add_op1); end
        complete_flush0();
    endtask

    task automatic test_stall();
        logic [31:0] r1, r2;
        @(negedge clk);
        drive_brch0(32'h1234_5678, 32'h0000_0ABC);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            r1 = $urandom; r2 = $urandom;
            if0.excp_flush_req = 1'($urandom_range(0, 1));
            if0.excp_flush_add_op1 = r1; if0.excp_flush_add_op2 = r2;
            drive_brch0(r2, r1);
            if0.pipe_flush_ack = 1'b0;
            #1;
            checks++; if (if0.pipe_flush_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %b exp 1", i, if0.pipe_flush_req); end
            checks++; if (if0.pipe_flush_add_op1 !== 32'h1234_5678 || if0.pipe_flush_add_op2 !== 32'h0000_0ABC) begin errors++; $display("FAIL stall_ops[%0d]: got %h/%h exp 12345678/00000abc", i, if0.pipe_flush_add_op1, if0.pipe_flush_add_op2); end
            checks++; if (if0.pipe_flush_src !== 1'b0) begin errors++; $display("FAIL stall_src[%0d]: got %b exp 0", i, if0.pipe_flush_src); end
            checks++; if (if0.excp_flush_ack !== 1'b0 || if0.brch_flush_ack !== 1'b0) begin errors++; $display("FAIL stall_acks[%0d]: got %b%b exp 00", i, if0.excp_flush_ack, if0.brch_flush_ack); end
            @(negedge clk);
        end
        idle_inputs();
        if0.pipe_flush_ack = 1'b1;
        @(negedge clk);
        if0.pipe_flush_ack = 1'b0;
        repeat (GAP0) @(negedge clk);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive_excp0(32'hFFFF_FFFC, 32'h0000_0008);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (if0.pipe_flush_src !== 1'b1 || if0.pipe_flush_add_op1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_capture: got src=%b op1=%h exp src=1 op1=fffffffc", if0.pipe_flush_src, if0.pipe_flush_add_op1); end
`ifdef E203_FLUSH_PC_PRECALC_EN
        checks++; if (if0.pipe_flush_pc !== 32'h0000_0004) begin errors++; $display("FAIL wrap_pc: got %h exp 00000004", if0.pipe_flush_pc); end
`endif
        complete_flush0();
    endtask

    task automatic test_reset_pend();
        @(negedge clk);
        drive_brch0(32'h0000_1000, 32'h0000_0010);
        @(negedge clk);
        drive_brch0(32'h0000_2000, 32'h0000_0020);
        rst_n = 1'b0;
        #1;
        checks++; if (if0.brch_flush_ack !== 1'b0) begin errors++; $display("FAIL rstpend_ack_in_reset: got %b exp 0", if0.brch_flush_ack); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (if0.pipe_flush_req !== 1'b0 || if0.flush_busy !== 1'b0) begin errors++; $display("FAIL rstpend_idle: got req=%b busy=%b exp 0/0", if0.pipe_flush_req, if0.flush_busy); end
        checks++; if (if0.pipe_flush_add_op1 !== 32'h0 || if0.pipe_flush_add_op2 !== 32'h0) begin errors++; $display("FAIL rstpend_ops: got %h/%h exp 0/0", if0.pipe_flush_add_op1, if0.pipe_flush_add_op2); end
        checks++; if (if0.brch_flush_ack !== 1'b1) begin errors++; $display("FAIL rstpend_reack: got %b exp 1", if0.brch_flush_ack); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (if0.pipe_flush_add_op1 !== 32'h0000_2000) begin errors++; $display("FAIL rstpend_new_op1: got %h exp 00002000", if0.pipe_flush_add_op1); end
        complete_flush0();
    endtask

    task automatic test_back_to_back_gap0();
        @(negedge clk);
        if1.brch_flush_req = 1'b1; if1.brch_flush_add_op1 = 32'h0000_4000; if1.brch_flush_add_op2 = 32'h4;
        #1;
        checks++; if (if1.brch_flush_ack !== 1'b1) begin errors++; $display("FAIL gap0_ack1: got %b exp 1", if1.brch_flush_ack); end
        @(negedge clk);
        if1.brch_flush_add_op1 = 32'h0000_5000; if1.brch_flush_add_op2 = 32'h8;
        if1.pipe_flush_ack = 1'b1;
        #1;
        checks++; if (if1.pipe_flush_req !== 1'b1 || if1.brch_flush_ack !== 1'b0) begin errors++; $display("FAIL gap0_pend: got req=%b ack=%b exp 1/0", if1.pipe_flush_req, if1.brch_flush_ack); end
        @(negedge clk);
        if1.pipe_flush_ack = 1'b0;
        #1;
        checks++; if (if1.flush_busy !== 1'b0 || if1.brch_flush_ack !== 1'b1) begin errors++; $display("FAIL gap0_reack: got busy=%b ack=%b exp 0/1", if1.flush_busy, if1.brch_flush_ack); end
        @(negedge clk);
        if1.brch_flush_req = 1'b0;
        if1.pipe_flush_ack = 1'b1;
        #1;
        checks++; if (if1.flush_busy !== 1'b1 || if1.pipe_flush_add_op1 !== 32'h0000_5000) begin errors++; $display("FAIL gap0_second: got busy=%b op1=%h exp 1/00005000", if1.flush_busy, if1.pipe_flush_add_op1); end
        @(negedge clk);
        if1.pipe_flush_ack = 1'b0;
        #1;
        checks++; if (if1.flush_busy !== 1'b0) begin errors++; $display("FAIL gap0_done: got %b exp 0", if1.flush_busy); end
    endtask

    // Reference model: one outstanding flush, then a countdown of idle cycles after the IFU takes it.
    task automatic test_random();
        logic        m_pend, m_src, e_xr, e_br, r, pa, ex_xa, ex_ba, idle;
        int          m_gap;
        logic [31:0] m_op1, m_op2, m_pc, e_x1, e_x2, e_b1, e_b2;
        m_pend = 1'b0; m_src = 1'b0; m_gap = 0; m_op1 = '0; m_op2 = '0; m_pc = '0;
        e_xr = 1'b0; e_br = 1'b0; e_x1 = '0; e_x2 = '0; e_b1 = '0; e_b2 = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!e_xr && $urandom_range(0, 3) == 0) begin e_xr = 1'b1; e_x1 = $urandom; e_x2 = $urandom; end
            if (!e_br && $urandom_range(0, 2) == 0) begin e_br = 1'b1; e_b1 = $urandom; e_b2 = $urandom; end
            r  = ($urandom_range(0, 39) != 0);
            pa = 1'($urandom_range(0, 1));
            rst_n = r;
            if0.excp_flush_req = e_xr; if0.excp_flush_add_op1 = e_x1; if0.excp_flush_add_op2 = e_x2;
            if0.brch_flush_req = e_br; if0.brch_flush_add_op1 = e_b1; if0.brch_flush_add_op2 = e_b2;
            if0.pipe_flush_ack = pa;
            idle  = r && !m_pend && (m_gap == 0);
            ex_xa = idle && e_xr;
            ex_ba = idle && e_br && !e_xr;
            #1;
            checks++; if (if0.excp_flush_ack !== ex_xa) begin errors++; $display("FAIL rnd_excp_ack@%0d: got %b exp %b", cyc, if0.excp_flush_ack, ex_xa); end
            checks++; if (if0.brch_flush_ack !== ex_ba) begin errors++; $display("FAIL rnd_brch_ack@%0d: got %b exp %b", cyc, if0.brch_flush_ack, ex_ba); end
            checks++; if (if0.pipe_flush_req !== m_pend) begin errors++; $display("FAIL rnd_pipe_req@%0d: got %b exp %b", cyc, if0.pipe_flush_req, m_pend); end
            checks++; if (if0.flush_busy !== (m_pend || m_gap > 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b exp %b", cyc, if0.flush_busy, (m_pend || m_gap > 0)); end
            checks++; if (if0.pipe_flush_add_op1 !== m_op1 || if0.pipe_flush_add_op2 !== m_op2) begin errors++; $display("FAIL rnd_ops@%0d: got %h/%h exp %h/%h", cyc, if0.pipe_flush_add_op1, if0.pipe_flush_add_op2, m_op1, m_op2); end
            checks++; if (if0.pipe_flush_src !== m_src) begin errors++; $display("FAIL rnd_src@%0d: got %b exp %b", cyc, if0.pipe_flush_src, m_src); end
`ifdef E203_FLUSH_PC_PRECALC_EN
            checks++; if (if0.pipe_flush_pc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h exp %h", cyc, if0.pipe_flush_pc, m_pc); end
`endif
            if (!r) begin
                m_pend = 1'b0; m_gap = 0; m_op1 = '0; m_op2 = '0; m_src = 1'b0; m_pc = '0;
            end else if (m_pend) begin
                if (pa) begin m_pend = 1'b0; m_gap = GAP0; end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (ex_xa) begin
                m_pend = 1'b1; m_op1 = e_x1; m_op2 = e_x2; m_src = 1'b1; m_pc = e_x1 + e_x2;
            end else if (ex_ba) begin
                m_pend = 1'b1; m_op1 = e_b1; m_op2 = e_b2; m_src = 1'b0; m_pc = e_b1 + e_b2;
            end
            if (ex_xa) e_xr = 1'b0;
            if (ex_ba) e_br = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_brch_basic();
        test_priority();
        test_stall();
        test_wrap();
        test_reset_pend();
        test_back_to_back_gap0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e203_exu_flush_ctrl.md
E203_EXU_FLUSH_CTRL -- requirements
Module: e203_exu_flush_ctrl

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32: width of all PC operand ports.
REQ-002 SHALL have parameter FLUSH_GAP, default 2: idle cycles enforced after each completed flush, legal range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port excp_flush_req, input, 1: exception/interrupt flush request, held until acked.
REQ-006 SHALL have ports excp_flush_add_op1 and excp_flush_add_op2, input, PC_SIZE each: exception target operands.
REQ-007 SHALL have port excp_flush_ack, output, 1: exception request accepted this cycle.
REQ-008 SHALL have port brch_flush_req, input, 1: branch-mispredict/fence.i/mret/dret flush request, held until acked.
REQ-009 SHALL have ports brch_flush_add_op1 and brch_flush_add_op2, input, PC_SIZE each: branch target operands.
REQ-010 SHALL have port brch_flush_ack, output, 1: branch request accepted this cycle.
REQ-011 SHALL have port pipe_flush_req, output, 1: registered flush request to IFU.
REQ-012 SHALL have port pipe_flush_ack, input, 1: IFU accepts the flush.
REQ-013 SHALL have ports pipe_flush_add_op1 and pipe_flush_add_op2, output, PC_SIZE each: captured target operands.
REQ-014 SHALL have port pipe_flush_pc, output, PC_SIZE, present only with E203_FLUSH_PC_PRECALC_EN: precomputed target.
REQ-015 SHALL have port pipe_flush_src, output, 1: 1 = captured flush is exception, 0 = branch.
REQ-016 SHALL have port flush_busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, PEND, GAP.
REQ-018 In IDLE, excp_flush_req=1 SHALL assert excp_flush_ack combinationally, capture excp operands, set src=1, next state PEND.
REQ-019 In IDLE, brch_flush_req=1 with excp_flush_req=0 SHALL assert brch_flush_ack, capture brch operands, set src=0, next state PEND.
REQ-020 brch_flush_ack SHALL be 0 in any cycle where excp_flush_req=1; at most one ack SHALL be high per cycle.
REQ-021 Both acks SHALL be 0 in PEND and GAP; requests there SHALL be left pending, not dropped.
REQ-022 pipe_flush_req SHALL equal (state==PEND); first assertion one cycle after the accepting ack.
REQ-023 In PEND, pipe_flush_add_op1/op2/src SHALL hold stable until pipe_flush_ack=1.
REQ-024 On pipe_flush_ack=1 in PEND: FLUSH_GAP=0 -> IDLE; else load gap counter with FLUSH_GAP-1 and go GAP.
REQ-025 In GAP: counter==0 -> IDLE, else decrement; GAP SHALL last exactly FLUSH_GAP cycles.
REQ-026 pipe_flush_ack outside PEND SHALL be ignored.
REQ-027 Gap counter width SHALL be 4 bits.
REQ-028 Captured operand registers SHALL load only on an ack cycle.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, clear gap counter, operand registers, src, and pipe_flush_pc to 0.
REQ-030 During and after reset, pipe_flush_req and flush_busy SHALL be 0 and any in-flight PEND flush SHALL be discarded.
REQ-031 Acks in the reset cycle SHALL be 0.

Configuration
REQ-032 Macro E203_FLUSH_PC_PRECALC_EN defined: a register SHALL capture op1+op2 modulo 2^PC_SIZE (carry dropped) on each ack and drive pipe_flush_pc.
REQ-033 Macro E203_FLUSH_PC_PRECALC_EN undefined: pipe_flush_pc port and adder SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, then brch_flush_req=1 with ops 0x8000_0100/0x0000_0004 -> brch_flush_ack at N, pipe_flush_req at N+1, op1=0x8000_0100, src=0, pipe_flush_pc=0x8000_0104 (macro on).
REQ-035 excp and brch requests together in IDLE -> only excp_flush_ack; brch acked only after excp's pipe handshake plus 2 GAP cycles (FLUSH_GAP=2).
REQ-036 pipe_flush_ack held 0 for 5 cycles in PEND while inputs change -> pipe_flush_req and operands stable, no acks issued.
REQ-037 Ops 0xFFFF_FFFC + 0x0000_0008 with macro on -> pipe_flush_pc=0x0000_0004.
REQ-038 rst_n=0 for one cycle during PEND -> next cycle IDLE, pipe_flush_req=0, outputs 0, and pending brch request re-acked after release.
REQ-039 FLUSH_GAP=0, back-to-back brch requests -> new ack in cycle after pipe handshake, flush_busy low for that cycle only.
